// File: rtl/ctrl_unit.sv
// rtl/ctrl_unit.sv - registered MIPS32 main opcode decoder for the ID/EX boundary
module ctrl_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUOp,
  output logic       Jump,
  output logic       Branch,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       ALUSrc,
  output logic       RegWrite,
  output logic       sign_or_zero
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  logic [1:0] reg_dst_d, mem_to_reg_d, alu_op_d;
  logic       jump_d, branch_d, mem_read_d, mem_write_d;
  logic       alu_src_d, reg_write_d, sign_or_zero_d;

  logic [12:0] ctrl_d, ctrl_q;

  // Unknown or unlisted opcodes fall to the default and become a bubble.
  always_comb begin
    reg_dst_d      = 2'b00;
    mem_to_reg_d   = 2'b00;
    alu_op_d       = 2'b00;
    jump_d         = 1'b0;
    branch_d       = 1'b0;
    mem_read_d     = 1'b0;
    mem_write_d    = 1'b0;
    alu_src_d      = 1'b0;
    reg_write_d    = 1'b0;
    sign_or_zero_d = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        reg_dst_d      = 2'b01;
        alu_op_d       = 2'b10;
        reg_write_d    = 1'b1;
        sign_or_zero_d = 1'b1;
      end
      OP_LW: begin
        mem_to_reg_d   = 2'b01;
        mem_read_d     = 1'b1;
        alu_src_d      = 1'b1;
        reg_write_d    = 1'b1;
        sign_or_zero_d = 1'b1;
      end
      OP_SW: begin
        mem_write_d    = 1'b1;
        alu_src_d      = 1'b1;
        sign_or_zero_d = 1'b1;
      end
      OP_BEQ: begin
        alu_op_d       = 2'b01;
        branch_d       = 1'b1;
        sign_or_zero_d = 1'b1;
      end
      OP_J: begin
        jump_d = 1'b1;
      end
      OP_JAL: begin
        jump_d       = 1'b1;
        reg_dst_d    = 2'b10;
        mem_to_reg_d = 2'b10;
        reg_write_d  = 1'b1;
      end
      OP_ADDI, OP_ADDIU: begin
        alu_src_d      = 1'b1;
        reg_write_d    = 1'b1;
        sign_or_zero_d = 1'b1;
      end
      default: begin
        reg_dst_d = 2'b00;
      end
    endcase
  end

  assign ctrl_d = {reg_dst_d, mem_to_reg_d, alu_op_d, jump_d, branch_d,
                   mem_read_d, mem_write_d, alu_src_d, reg_write_d, sign_or_zero_d};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign {RegDst, MemtoReg, ALUOp, Jump, Branch,
          MemRead, MemWrite, ALUSrc, RegWrite, sign_or_zero} = ctrl_q;

endmodule

// File: tb/tb_ctrl_unit.sv
// tb/tb_ctrl_unit.sv - scoreboard bench for ctrl_unit
module tb_ctrl_unit;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [1:0] RegDst, MemtoReg, ALUOp;
  logic       Jump, Branch, MemRead, MemWrite, ALUSrc, RegWrite, sign_or_zero;

  logic [12:0] obs;
  logic [12:0] exp_q[$];
  int n_checks;
  int n_pass;

  ctrl_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUOp(ALUOp),
    .Jump(Jump), .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite),
    .ALUSrc(ALUSrc), .RegWrite(RegWrite), .sign_or_zero(sign_or_zero)
  );

  assign obs = {RegDst, MemtoReg, ALUOp, Jump, Branch,
                MemRead, MemWrite, ALUSrc, RegWrite, sign_or_zero};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word layout: RegDst MemtoReg ALUOp Jump Branch MemRead MemWrite ALUSrc RegWrite sign_or_zero
  function automatic logic [12:0] expect_word(input logic [5:0] op);
    if ($isunknown(op)) return 13'b0;
    case (op)
      6'b000000: return {2'b01, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      6'b100011: return {2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      6'b101011: return {2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      6'b000100: return {2'b00, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      6'b000010: return {2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      6'b000011: return {2'b10, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      6'b001000,
      6'b001001: return {2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      default:   return 13'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [12:0] got, input logic [12:0] want);
    n_checks++;
    if (got === want) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %013b expected %013b", tag, got, want);
    end
  endtask

  // Drive at negedge, push expectation, compare just after the capturing edge.
  task automatic apply(input string tag, input logic [5:0] op);
    logic [12:0] want;
    @(negedge clk);
    opcode = op;
    exp_q.push_back(expect_word(op));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_empty"}, obs, 13'h1fff ^ obs);
    end else begin
      want = exp_q.pop_front();
      check(tag, obs, want);
    end
  endtask

  initial begin
    logic [5:0] legal [8];
    logic [5:0] op;
    legal = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
              6'b000010, 6'b000011, 6'b001000, 6'b001001};
    n_checks = 0;
    n_pass   = 0;

    reset  = 1'b0;
    opcode = 6'b100011;
    #2;
    check("reset_async", obs, 13'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", obs, 13'b0);

    @(negedge clk);
    reset = 1'b1;
    #2;
    check("release_no_edge", obs, 13'b0);
    exp_q.push_back(expect_word(6'b100011));
    @(posedge clk);
    #1;
    check("release_lw", obs, exp_q.pop_front());

    apply("lw", 6'b100011);
    apply("sw", 6'b101011);
    apply("beq", 6'b000100);
    apply("rtype", 6'b000000);
    apply("j", 6'b000010);
    apply("jal", 6'b000011);
    apply("addi", 6'b001000);
    apply("illegal", 6'b111111);
    apply("addiu", 6'b001001);
    apply("xop", 6'bxxxxxx);
    apply("rtype2", 6'b000000);

    // Mid-cycle opcode change must not reach the outputs before the next edge.
    @(negedge clk);
    opcode = 6'b000010;
    #2;
    check("hold_between_edges", obs, expect_word(6'b000000));

    apply("jal2", 6'b000011);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("async_mid", obs, 13'b0);
    @(posedge clk);
    #1;
    check("async_hold", obs, 13'b0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 1) == 0) ? legal[$urandom_range(0, 7)] : 6'($urandom_range(0, 63));
      apply("rand", op);
      check("mem_excl", {12'b0, MemRead & MemWrite}, 13'b0);
      check("jb_excl", {12'b0, Jump & Branch}, 13'b0);
    end

    check("queue_drained", {12'b0, exp_q.size() != 0}, 13'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ctrl_unit.md
# ctrl_unit

Main decoder for the pipelined MIPS32 core. It sits in the ID stage and maps the 6-bit instruction opcode to datapath control signals. Those signals steer register-destination selection, write-back source, ALU operand and operation class, memory access, branch and jump. Outputs are registered, so they are already aligned with the ID/EX pipeline boundary.

## Interface
Parameters: none.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset; one clock domain
- opcode  input  6  instruction bits [31:26]
- RegDst  output  2  write-register select: 00 = rt, 01 = rd, 10 = $31
- MemtoReg  output  2  write-back source: 00 = ALU result, 01 = memory data, 10 = PC+4
- ALUOp  output  2  ALU class: 00 = add, 01 = subtract (compare), 10 = R-type (funct-decoded), 11 = reserved, never driven
- Jump  output  1  select jump target for next PC
- Branch  output  1  conditional branch on ALU zero
- MemRead  output  1  data-memory read enable
- MemWrite  output  1  data-memory write enable
- ALUSrc  output  1  ALU operand B: 0 = register rt, 1 = extended immediate
- RegWrite  output  1  register-file write enable
- sign_or_zero  output  1  immediate extension: 1 = sign-extend, 0 = zero-extend

## Operation
- A combinational decode of opcode produces the next control word. The control word is captured into output registers on each rising clk.
- Decode table (unlisted signals are 0):
  - 000000 R-type: RegDst=01, ALUOp=10, RegWrite=1, sign_or_zero=1
  - 100011 lw: MemtoReg=01, ALUOp=00, MemRead=1, ALUSrc=1, RegWrite=1, sign_or_zero=1
  - 101011 sw: ALUOp=00, MemWrite=1, ALUSrc=1, sign_or_zero=1
  - 000100 beq: ALUOp=01, Branch=1, sign_or_zero=1
  - 000010 j: Jump=1
  - 000011 jal: Jump=1, RegDst=10, MemtoReg=10, RegWrite=1
  - 001000 addi, 001001 addiu: ALUOp=00, ALUSrc=1, RegWrite=1, sign_or_zero=1
- Any other opcode, including X/Z: the all-zero control word (pipeline bubble). No register write, no memory access, no PC redirect.
- MemRead and MemWrite are never both 1. Jump and Branch are never both 1.
- No internal state beyond the output registers. Each cycle is independent of history.

## Timing
- Latency: 1 cycle. The opcode present before rising edge N appears on the outputs after edge N.
- Reset: reset=0 forces every output to 0 immediately, without waiting for clk. This includes RegDst=00, MemtoReg=00, ALUOp=00 and sign_or_zero=0.
- While reset=0, outputs stay 0 regardless of opcode or clk.
- On release (reset 0→1), outputs remain 0 until the first rising clk. That edge loads the decode of the current opcode.
- Reset asserted mid-stream: outputs clear asynchronously and the in-flight control word is discarded.
- An opcode change between edges has no effect on the outputs until the next edge. Outputs are glitch-free, since they are driven only from flops.

## Test plan
- Reset: hold reset=0 for 2 cycles with opcode=100011 → all outputs 0. Release reset; after the first rising edge the outputs equal the lw word.
- lw then sw on consecutive cycles:
  - lw: MemtoReg=01, MemRead=1, ALUSrc=1, RegWrite=1, sign_or_zero=1.
  - Next cycle, sw: MemWrite=1, MemRead=0, RegWrite=0, ALUSrc=1.
- beq (000100) → Branch=1, ALUOp=01, ALUSrc=0, RegWrite=0. Then R-type (000000) → RegDst=01, ALUOp=10, RegWrite=1, Branch=0.
- j (000010) → Jump=1, all else 0. Then jal (000011) → Jump=1, RegDst=10, MemtoReg=10, RegWrite=1.
- addi (001000) → ALUSrc=1, RegWrite=1, ALUOp=00, RegDst=00, sign_or_zero=1. Then illegal 111111 → all outputs 0.
- Async reset mid-run: while the outputs hold the jal word, drop reset=0 between clock edges → all outputs 0 before the next edge.
